// File: rtl/cache_controller_pkg.sv
// Shared definitions for the read-only direct-mapped cache controller.
//
// Contents:
//   state_t     - controller FSM state encoding
//   TAG_W/OFS_W - CPU address field widths (index width is a module parameter)
//   WORD_W      - CPU word width
//   BLOCK_W     - cache line / memory block width
//   block_word  - selects one word of a block by word offset
package cache_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_MISS_REQ  = 3'd2,
    ST_MISS_WAIT = 3'd3,
    ST_REFILL    = 3'd4
  } state_t;

  localparam int TAG_W   = 3;
  localparam int OFS_W   = 2;
  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;

  // Word k of a block lives at bits [32k+31:32k]; {ofs, 5'd0} is ofs*32.
  function automatic logic [WORD_W-1:0] block_word(input logic [BLOCK_W-1:0] blk,
                                                   input logic [OFS_W-1:0]   ofs);
    return blk[{ofs, 5'd0} +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_controller_array.sv
// Line storage for the direct-mapped cache: valid bits, tags and data blocks.
//
// Ports:
//   i_clk        - system clock
//   i_rst        - synchronous active-low reset, clears every valid bit
//   i_rd_index   - line index for the combinational read
//   o_rd_valid   - valid bit of the indexed line
//   o_rd_tag     - tag of the indexed line
//   o_rd_data    - data block of the indexed line
//   i_wr_en      - write strobe, line is written on the rising edge
//   i_wr_index   - line index to write
//   i_wr_tag     - tag to store
//   i_wr_data    - block to store
//
// Tags and data have no reset: a line is never trusted until its valid bit
// has been set by a write, so their power-up contents do not matter.
module cache_array
  import cache_controller_pkg::*;
#(
  parameter int INDEX_W = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [INDEX_W-1:0] i_rd_index,
  output logic               o_rd_valid,
  output logic [TAG_W-1:0]   o_rd_tag,
  output logic [BLOCK_W-1:0] o_rd_data,
  input  logic               i_wr_en,
  input  logic [INDEX_W-1:0] i_wr_index,
  input  logic [TAG_W-1:0]   i_wr_tag,
  input  logic [BLOCK_W-1:0] i_wr_data
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0]   r_valid;
  logic [TAG_W-1:0]   r_tag  [0:LINES-1];
  logic [BLOCK_W-1:0] r_data [0:LINES-1];

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_index]  <= i_wr_tag;
      r_data[i_wr_index] <= i_wr_data;
    end
  end

  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_data  = r_data[i_rd_index];

endmodule

// File: rtl/cache_controller.sv
// Read-only direct-mapped cache controller between a CPU and main memory.
//
// Ports:
//   clk, rst        - clock, synchronous active-low reset
//   cpu_req         - read request, sampled only while idle
//   cpu_addr        - word address {tag, index, offset}
//   cpu_ready       - one-cycle pulse, cpu_data valid
//   cpu_data        - requested word, held until the next cpu_ready
//   busy            - high whenever the controller is not idle
//   mem_read        - memory read strobe (memory acts on its rising edge)
//   mem_addr        - block-aligned miss address {tag, index, 2'b00}
//   mem_data_ready  - memory completion flag (sticky until the next mem_read rise)
//   mem_block       - block returned by memory
//   hit_count       - lookup hits, wraps
//   miss_count      - lookup misses, wraps
//   o_dbg_state     - current FSM state for observation
//
// Handshake: cpu_req is a level that is only looked at in IDLE; anything
// asserted while busy is dropped, not queued. Every accepted request ends in
// exactly one cpu_ready pulse (one cycle after LOOKUP on a hit, one cycle
// after REFILL on a miss). On the memory side mem_read stays high from
// MISS_REQ until completion is seen, and mem_data_ready is only trusted from
// the second MISS_WAIT cycle on, because the flag may still be high from the
// previous access while memory reacts to the new rising edge.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int INDEX_W = 10,
  parameter int CNT_W   = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cpu_req,
  input  logic [TAG_W+INDEX_W+OFS_W-1:0]   cpu_addr,
  output logic                             cpu_ready,
  output logic [WORD_W-1:0]                cpu_data,
  output logic                             busy,
  output logic                             mem_read,
  output logic [TAG_W+INDEX_W+OFS_W-1:0]   mem_addr,
  input  logic                             mem_data_ready,
  input  logic [BLOCK_W-1:0]               mem_block,
  output logic [CNT_W-1:0]                 hit_count,
  output logic [CNT_W-1:0]                 miss_count,
  output logic [2:0]                       o_dbg_state
);

  localparam int ADDR_W = TAG_W + INDEX_W + OFS_W;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_wait_first;
  logic                r_cpu_ready;
  logic [WORD_W-1:0]   r_cpu_data;
  logic                r_busy;
  logic                r_mem_read;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [CNT_W-1:0]    r_hit_cnt;
  logic [CNT_W-1:0]    r_miss_cnt;

  logic [INDEX_W-1:0]  w_index;
  logic [TAG_W-1:0]    w_tag;
  logic [OFS_W-1:0]    w_ofs;
  logic                w_rd_valid;
  logic [TAG_W-1:0]    w_rd_tag;
  logic [BLOCK_W-1:0]  w_rd_data;
  logic                w_hit;
  logic                w_wr_en;

  assign w_index = r_addr[INDEX_W+OFS_W-1:OFS_W];
  assign w_tag   = r_addr[ADDR_W-1:ADDR_W-TAG_W];
  assign w_ofs   = r_addr[OFS_W-1:0];
  assign w_hit   = w_rd_valid && (w_rd_tag == w_tag);

  // The line is written on the edge that leaves REFILL; a reset on that same
  // edge abandons the miss, so the write is suppressed too.
  assign w_wr_en = (r_state == ST_REFILL) && rst;

  cache_array #(
    .INDEX_W (INDEX_W)
  ) u_array (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_rd_index (w_index),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_data  (w_rd_data),
    .i_wr_en    (w_wr_en),
    .i_wr_index (w_index),
    .i_wr_tag   (w_tag),
    .i_wr_data  (mem_block)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_addr       <= '0;
      r_wait_first <= 1'b0;
      r_cpu_ready  <= 1'b0;
      r_cpu_data   <= '0;
      r_busy       <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_addr   <= '0;
      r_hit_cnt    <= '0;
      r_miss_cnt   <= '0;
    end else begin
      r_cpu_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cpu_req) begin
            r_addr  <= cpu_addr;
            r_busy  <= 1'b1;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_cpu_ready <= 1'b1;
            r_cpu_data  <= block_word(w_rd_data, w_ofs);
            r_hit_cnt   <= r_hit_cnt + CNT_W'(1);
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end else begin
            r_miss_cnt  <= r_miss_cnt + CNT_W'(1);
            r_mem_read  <= 1'b1;
            r_mem_addr  <= {w_tag, w_index, {OFS_W{1'b0}}};
            r_state     <= ST_MISS_REQ;
          end
        end
        ST_MISS_REQ: begin
          r_wait_first <= 1'b1;
          r_state      <= ST_MISS_WAIT;
        end
        ST_MISS_WAIT: begin
          // First cycle: the completion flag may be left over from the
          // previous access, so it is not looked at.
          if (r_wait_first) begin
            r_wait_first <= 1'b0;
          end else if (mem_data_ready) begin
            r_mem_read <= 1'b0;
            r_state    <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          r_cpu_ready <= 1'b1;
          r_cpu_data  <= block_word(mem_block, w_ofs);
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_busy     <= 1'b0;
          r_mem_read <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_ready   = r_cpu_ready;
  assign cpu_data    = r_cpu_data;
  assign busy        = r_busy;
  assign mem_read    = r_mem_read;
  assign mem_addr    = r_mem_addr;
  assign hit_count   = r_hit_cnt;
  assign miss_count  = r_miss_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller. Counters are instantiated 8 bits
// wide so counter wrap-around is reachable in a short run.
module tb_cache_controller;

  localparam int INDEX_W = 10;
  localparam int CNT_W   = 8;

  // ---------------- clock / reset / DUT ----------------
  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cpu_req = 1'b0;
  logic [14:0]        cpu_addr = '0;
  logic               cpu_ready;
  logic [31:0]        cpu_data;
  logic               busy;
  logic               mem_read;
  logic [14:0]        mem_addr;
  logic               mem_data_ready = 1'b0;
  logic [127:0]       mem_block = '0;
  logic [CNT_W-1:0]   hit_count;
  logic [CNT_W-1:0]   miss_count;
  logic [2:0]         o_dbg_state;

  always #5 clk = ~clk;

  cache_controller #(.INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_req        (cpu_req),
    .cpu_addr       (cpu_addr),
    .cpu_ready      (cpu_ready),
    .cpu_data       (cpu_data),
    .busy           (busy),
    .mem_read       (mem_read),
    .mem_addr       (mem_addr),
    .mem_data_ready (mem_data_ready),
    .mem_block      (mem_block),
    .hit_count      (hit_count),
    .miss_count     (miss_count),
    .o_dbg_state    (o_dbg_state)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / reference model ----------------
  int               vec_cnt = 0;
  int               err_cnt = 0;
  logic [31:0]      exp_q[$];
  bit               mdl_valid [1024];
  logic [2:0]       mdl_tag   [1024];
  logic [CNT_W-1:0] exp_hits   = '0;
  logic [CNT_W-1:0] exp_misses = '0;

  // Memory contents: every word encodes its own address, so a wrong block,
  // wrong word or stale block all show up as a data difference.
  function automatic logic [127:0] blk(input logic [14:0] a);
    logic [127:0] b;
    logic [1:0]   kk;
    b = '0;
    for (int k = 0; k < 4; k++) begin
      kk = k[1:0];
      b[32*k +: 32] = {a[14:2], kk, a ^ 15'h2C3D, 2'b10};
    end
    return b;
  endfunction

  function automatic logic [31:0] exp_word(input logic [14:0] a);
    logic [127:0] b;
    b = blk({a[14:2], 2'b00});
    return b[32*a[1:0] +: 32];
  endfunction

  // One CPU read as the cache rules describe it: hit if the line for this
  // index holds this tag, otherwise count a miss and the line now holds it.
  function automatic bit model_access(input logic [14:0] a);
    logic [9:0] idx;
    bit         hit;
    idx = a[11:2];
    hit = mdl_valid[idx] && (mdl_tag[idx] == a[14:12]);
    if (hit) exp_hits++;
    else begin
      exp_misses++;
      mdl_valid[idx] = 1'b1;
      mdl_tag[idx]   = a[14:12];
    end
    exp_q.push_back(exp_word(a));
    return hit;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) mdl_valid[i] = 1'b0;
    exp_hits   = '0;
    exp_misses = '0;
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  int          obs_ready_cnt;
  int          obs_lat;
  int          obs_rises;
  logic [31:0] obs_data;
  logic [14:0] obs_maddr;
  bit          obs_addr_unstable;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    cpu_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  // Issues one request and plays the memory side. 'stale' is how many extra
  // sampling points the previous completion flag stays high after mem_read
  // rises. With 'hold' the request line stays high until cpu_ready.
  task automatic cpu_access(input logic [14:0] a, input int stale, input bit hold);
    int drop_cnt;
    int lat_cnt;
    bit prev_mr;
    bit pending_drop;
    bit waiting;
    obs_ready_cnt = 0; obs_lat = 0; obs_rises = 0; obs_data = '0; obs_maddr = '0;
    obs_addr_unstable = 1'b0;
    drop_cnt = 0; lat_cnt = 0; prev_mr = 1'b0; pending_drop = 1'b0; waiting = 1'b0;
    @(negedge clk);
    cpu_req  = 1'b1;
    cpu_addr = a;
    @(posedge clk);
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (!hold) cpu_req = 1'b0;
      if (mem_read && !prev_mr) begin
        obs_rises++;
        obs_maddr    = mem_addr;
        drop_cnt     = stale;
        pending_drop = 1'b1;
        waiting      = 1'b0;
      end
      if (mem_read && obs_rises > 0 && mem_addr !== obs_maddr) obs_addr_unstable = 1'b1;
      prev_mr = mem_read;
      if (waiting) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          mem_block      = blk(obs_maddr);
          mem_data_ready = 1'b1;
          waiting        = 1'b0;
        end
      end else if (pending_drop) begin
        if (drop_cnt == 0) begin
          mem_data_ready = 1'b0;
          pending_drop   = 1'b0;
          lat_cnt        = $urandom_range(1, 4);
          waiting        = 1'b1;
        end else begin
          drop_cnt--;
        end
      end
      if (cpu_ready) begin
        obs_ready_cnt++;
        if (obs_ready_cnt == 1) begin
          obs_data = cpu_data;
          obs_lat  = c;
          cpu_req  = 1'b0;
        end
      end
      if (obs_ready_cnt > 0 && c >= obs_lat + 3) break;
    end
    cpu_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    vec_cnt++; if (cpu_ready !== 1'b0) begin err_cnt++; $display("FAIL reset_cpu_ready got=%b exp=0", cpu_ready); end
    vec_cnt++; if (cpu_data !== 32'h0) begin err_cnt++; $display("FAIL reset_cpu_data got=%h exp=0", cpu_data); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vec_cnt++; if (mem_read !== 1'b0 || mem_addr !== 15'h0) begin
      err_cnt++; $display("FAIL reset_mem got=%b/%h exp=0/0", mem_read, mem_addr); end
    vec_cnt++; if (hit_count !== '0 || miss_count !== '0) begin
      err_cnt++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
  endtask

  task automatic test_directed();
    logic [14:0] tbl [4];
    logic [14:0] a;
    logic [31:0] exp_d;
    bit          exp_hit;
    tbl[0] = 15'h0005; tbl[1] = 15'h0007; tbl[2] = 15'h1004; tbl[3] = 15'h0004;
    for (int i = 0; i < 4; i++) begin
      a = tbl[i];
      exp_hit = model_access(a);
      cpu_access(a, 0, 1'b0);
      exp_d = exp_q.pop_front();
      vec_cnt++; if (obs_ready_cnt !== 1) begin
        err_cnt++; $display("FAIL dir_ready_pulses addr=%h got=%0d exp=1", a, obs_ready_cnt); end
      vec_cnt++; if (obs_data !== exp_d) begin
        err_cnt++; $display("FAIL dir_data addr=%h got=%h exp=%h", a, obs_data, exp_d); end
      vec_cnt++; if (exp_hit ? (obs_lat !== 2 || obs_rises !== 0)
                             : (obs_rises !== 1 || obs_maddr !== {a[14:2], 2'b00} || obs_addr_unstable)) begin
        err_cnt++; $display("FAIL dir_traffic addr=%h got lat=%0d rises=%0d maddr=%h exp hit=%0d maddr=%h",
                            a, obs_lat, obs_rises, obs_maddr, exp_hit, {a[14:2], 2'b00}); end
      vec_cnt++; if (hit_count !== exp_hits || miss_count !== exp_misses) begin
        err_cnt++; $display("FAIL dir_counters addr=%h got=%0d/%0d exp=%0d/%0d",
                            a, hit_count, miss_count, exp_hits, exp_misses); end
    end
    vec_cnt++; if (hit_count !== 8'd1 || miss_count !== 8'd3) begin
      err_cnt++; $display("FAIL dir_final_counts got=%0d/%0d exp=1/3", hit_count, miss_count); end
  endtask

  task automatic test_stale_ready();
    logic [14:0] a;
    logic [31:0] exp_d;
    bit          exp_hit;
    a = {3'd6, 10'd300, 2'd2};
    mem_data_ready = 1'b1;             // left over from the previous completion
    mem_block      = blk(15'h0004);    // previous block still on the bus
    exp_hit = model_access(a);
    cpu_access(a, 2, 1'b0);
    exp_d = exp_q.pop_front();
    vec_cnt++; if (exp_hit || obs_ready_cnt !== 1 || obs_rises !== 1) begin
      err_cnt++; $display("FAIL stale_flow got ready=%0d rises=%0d exp ready=1 rises=1", obs_ready_cnt, obs_rises); end
    vec_cnt++; if (obs_data !== exp_d) begin
      err_cnt++; $display("FAIL stale_data got=%h exp=%h", obs_data, exp_d); end
    vec_cnt++; if (miss_count !== exp_misses) begin
      err_cnt++; $display("FAIL stale_miss_count got=%0d exp=%0d", miss_count, exp_misses); end
  endtask

  task automatic test_reset_mid_miss();
    logic [14:0] a;
    logic [31:0] exp_d;
    bit          seen;
    bit          exp_hit;
    a = {3'd5, 10'd77, 2'd1};
    seen = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = a;
    @(posedge clk);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (mem_read) begin seen = 1'b1; break; end
    end
    vec_cnt++; if (!seen) begin err_cnt++; $display("FAIL rstmiss_mem_read got=0 exp=1"); end
    mem_data_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    vec_cnt++; if (mem_read !== 1'b0 || busy !== 1'b0) begin
      err_cnt++; $display("FAIL rstmiss_outputs got mem_read=%b busy=%b exp=0/0", mem_read, busy); end
    vec_cnt++; if (hit_count !== '0 || miss_count !== '0 || cpu_ready !== 1'b0) begin
      err_cnt++; $display("FAIL rstmiss_counters got=%0d/%0d ready=%b exp=0/0/0", hit_count, miss_count, cpu_ready); end
    rst = 1'b1;
    model_reset();
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (cpu_ready || mem_read) seen = 1'b1;
    end
    vec_cnt++; if (seen) begin err_cnt++; $display("FAIL rstmiss_quiet got activity=1 exp=0"); end
    exp_hit = model_access(a);
    cpu_access(a, 0, 1'b0);
    exp_d = exp_q.pop_front();
    vec_cnt++; if (exp_hit || obs_rises !== 1 || miss_count !== 8'd1) begin
      err_cnt++; $display("FAIL rstmiss_reaccess got rises=%0d misses=%0d exp=1/1", obs_rises, miss_count); end
    vec_cnt++; if (obs_data !== exp_d) begin
      err_cnt++; $display("FAIL rstmiss_data got=%h exp=%h", obs_data, exp_d); end
  endtask

  task automatic test_hold_req();
    logic [14:0] a;
    logic [31:0] exp_d;
    bit          exp_hit;
    a = {3'd2, 10'd513, 2'd3};
    exp_hit = model_access(a);
    cpu_access(a, 0, 1'b1);
    exp_d = exp_q.pop_front();
    vec_cnt++; if (exp_hit || obs_ready_cnt !== 1 || obs_rises !== 1) begin
      err_cnt++; $display("FAIL hold_served got ready=%0d rises=%0d exp=1/1", obs_ready_cnt, obs_rises); end
    vec_cnt++; if (obs_data !== exp_d) begin
      err_cnt++; $display("FAIL hold_data got=%h exp=%h", obs_data, exp_d); end
    vec_cnt++; if (hit_count !== exp_hits || miss_count !== exp_misses) begin
      err_cnt++; $display("FAIL hold_counters got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, exp_hits, exp_misses); end
  endtask

  task automatic test_random();
    logic [14:0] a;
    logic [31:0] exp_d;
    bit          exp_hit;
    for (int i = 0; i < 80; i++) begin
      a = {3'($urandom_range(0, 1)), 10'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      exp_hit = model_access(a);
      cpu_access(a, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      exp_d = exp_q.pop_front();
      vec_cnt++; if (obs_ready_cnt !== 1 || obs_data !== exp_d) begin
        err_cnt++; $display("FAIL rnd_data addr=%h got=%h pulses=%0d exp=%h pulses=1", a, obs_data, obs_ready_cnt, exp_d); end
      vec_cnt++; if (exp_hit ? (obs_lat !== 2 || obs_rises !== 0)
                             : (obs_rises !== 1 || obs_maddr !== {a[14:2], 2'b00} || obs_addr_unstable)) begin
        err_cnt++; $display("FAIL rnd_traffic addr=%h got lat=%0d rises=%0d maddr=%h exp hit=%0d", a, obs_lat, obs_rises, obs_maddr, exp_hit); end
      vec_cnt++; if (hit_count !== exp_hits || miss_count !== exp_misses) begin
        err_cnt++; $display("FAIL rnd_counters addr=%h got=%0d/%0d exp=%0d/%0d", a, hit_count, miss_count, exp_hits, exp_misses); end
    end
  endtask

  task automatic test_counter_wrap();
    logic [14:0] a;
    logic [31:0] exp_d;
    bit          exp_hit;
    int          bad;
    do_reset();
    a = 15'h0123;
    exp_hit = model_access(a);
    cpu_access(a, 0, 1'b0);
    exp_d = exp_q.pop_front();
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      a = {3'd0, 10'd72, 2'($urandom_range(0, 3))};
      exp_hit = model_access(a);
      cpu_access(a, 0, 1'b0);
      exp_d = exp_q.pop_front();
      if (!exp_hit || obs_data !== exp_d || obs_lat !== 2) bad++;
      if (i == 254) begin
        vec_cnt++; if (hit_count !== 8'd255) begin
          err_cnt++; $display("FAIL wrap_pre got=%0d exp=255", hit_count); end
      end
    end
    vec_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL wrap_hits got bad=%0d exp=0", bad); end
    vec_cnt++; if (hit_count !== 8'd0 || miss_count !== 8'd1) begin
      err_cnt++; $display("FAIL wrap_counts got=%0d/%0d exp=0/1", hit_count, miss_count); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_stale_ready();
    test_hold_req();
    test_random();
    test_reset_mid_miss();
    test_counter_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
